pulse_encoder: RTL
==================

# pulse_encoder

Transmit-side physical encoder for the optical link: accepts a parallel packet and emits it on the LED drive line as single-cycle pulses whose spacing encodes each bit. Sits directly upstream of the receive-side decoder across the light path. Its output pulse train is decoded bit-exactly by that decoder: start pulse first, then one pulse per bit, LSB first.

## Interface
- PACKET_SIZE, default `PACKET_SIZE: payload bits per packet.
- COUNTER_SIZE, default `COUNTER_SIZE: gap counter width; must hold max(INTERVAL_HIGH, GUARD_INTERVAL).
- INTERVAL_LOW, default `INTERVAL_LOW: low cycles between pulses for a 0 bit.
- INTERVAL_HIGH, default `INTERVAL_HIGH: low cycles between pulses for a 1 bit.
- GUARD_INTERVAL, default `GUARD_INTERVAL: low cycles after the last pulse before the next packet may start.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- data  in  PACKET_SIZE  packet to send; sampled on accept.
- send  in  1  request; accept occurs on a cycle with send=1 and ready=1.
- ready  out  1  registered; 1 = a packet can be accepted this cycle.
- signal  out  1  registered LED drive; 1 = pulse.
- done  out  1  registered; 1-cycle strobe when a packet's guard interval completes.

## Operation
- States: IDLE, PULSE, GAP, GUARD.
- IDLE: signal=0, ready=1. On accept: latch data into shift register, set bit index 0, go to PULSE, ready←0.
- PULSE: signal=1 for exactly one cycle. The first PULSE of a packet is the start pulse. Subsequent pulses terminate the gap of bit index−1.
  - After the start pulse: load the gap counter from bit 0 and go to GAP.
  - After the pulse for bit PACKET_SIZE−1: go to GUARD.
- GAP: signal=0 for INTERVAL_HIGH cycles if the current bit is 1, or INTERVAL_LOW cycles if it is 0. Then go to PULSE and advance the bit index.
- GUARD: signal=0 for GUARD_INTERVAL cycles. Then go to IDLE with ready=1, and done=1 for that one cycle.
- Pulse count per packet = PACKET_SIZE+1.
- Legal parameters: 1 ≤ INTERVAL_LOW ≤ INTERVAL_HIGH−2 (keeps a 0 strictly below the receiver's 1 threshold of INTERVAL_HIGH−1); GUARD_INTERVAL ≥ 1. Out-of-range values are a configuration error, with no runtime check.
- Counter width arithmetic: the counter decrements to zero and never wraps.
- send while ready=0 is ignored (no error, no latch). data changes after accept have no effect.
- Reset mid-packet: next cycle signal=0, ready=1, done=0, state IDLE, and any buffered packet is discarded. The far-end decoder must be reset as well; a truncated pulse train leaves it mid-packet.
- Reset values: signal=0, ready=1, done=0.

## Timing
- Accept at edge of cycle T. The start pulse has signal=1 during cycle T+1.
- The pulse for bit i occurs 1 + Σ_{k≤i}(gap_k+1) cycles after T.
- The last pulse is at cycle L. Guard occupies L+1..L+GUARD_INTERVAL. ready=1 and done=1 at L+GUARD_INTERVAL+1.
- An accept in the same cycle that done=1 is legal. Its start pulse follows one cycle later, so back-to-back packets are separated by exactly GUARD_INTERVAL+1 low cycles.

## Configuration
- ENCODER_BUF_EN defined: adds a one-entry holding buffer.
  - ready = buffer empty, so ready stays 1 during transmission until one packet is queued.
  - On leaving GUARD, a queued packet starts immediately: its start pulse is in the cycle after the last guard cycle, and done still strobes that cycle.
  - Reset clears the buffer.
- ENCODER_BUF_EN undefined: no buffer; ready=1 only in IDLE, exactly as described above.

## Structure
- Shared definitions.v gains `GUARD_INTERVAL and the state encodings for IDLE/PULSE/GAP/GUARD.
- `PACKET_SIZE, `COUNTER_SIZE, `INTERVAL_LOW and `INTERVAL_HIGH stay shared with the decoder so both ends always agree.
- One natural sub-module: pulse_timer, a loadable down-counter (load value, load strobe, zero flag) of COUNTER_SIZE bits, used for both GAP and GUARD.

## Test plan
Bench parameters: PACKET_SIZE=8, INTERVAL_LOW=2, INTERVAL_HIGH=5, GUARD_INTERVAL=8.
- Send 0xA5 at T → pulses at T+1, T+7, T+10, T+16, T+19, T+22, T+28, T+31, T+37; ready/done=1 at T+46; decoder loopback yields data=0xA5 with irq.
- Send 0x00 at T → 9 pulses 3 cycles apart, last at T+25; done at T+34. Send 0xFF → last pulse T+49, done T+58.
- send held high continuously with data 0x3C then 0xC3 → two packets, low gap of 9 cycles between them, both decoded correctly; with ENCODER_BUF_EN, second accepted at T+1 and ready low until first completes.
- send asserted while busy (no buffer) → ignored; signal pattern identical to a single-packet run.
- reset at T+12 mid-packet → signal=0, ready=1, done=0 at T+13; new send 0x5A at T+14 transmits correctly after decoder reset.
- After reset with no send for 100 cycles → signal, done stay 0; ready stays 1.

Source files
------------

// File: rtl/pulse_encoder_pkg.sv
// pulse_encoder_pkg
//   Shared definitions for the optical-link pulse encoder: link-wide timing
//   defaults (kept in step with the receive-side decoder), the encoder state
//   encoding, and a helper that turns a low-interval length into a timer load.
//   Optional feature macro used by the encoder: ENCODER_BUF_EN.

`ifndef PACKET_SIZE
`define PACKET_SIZE 8
`endif
`ifndef COUNTER_SIZE
`define COUNTER_SIZE 4
`endif
`ifndef INTERVAL_LOW
`define INTERVAL_LOW 2
`endif
`ifndef INTERVAL_HIGH
`define INTERVAL_HIGH 5
`endif
`ifndef GUARD_INTERVAL
`define GUARD_INTERVAL 8
`endif

package pulse_encoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PULSE = 2'b01,
    ST_GAP   = 2'b10,
    ST_GUARD = 2'b11
  } enc_state_t;

  // The timer reports zero on the last low cycle of an interval, so an
  // interval of N low cycles is loaded as N-1.
  function automatic int interval_load(input int cycles);
    return cycles - 1;
  endfunction

endpackage

// File: rtl/pulse_timer.sv
// pulse_timer
//   Loadable down-counter shared by the gap and guard intervals. A load
//   strobe takes priority; otherwise the count decrements toward zero and
//   holds there (never wraps).
// Ports:
//   clock  in   system clock, posedge
//   reset  in   synchronous, active-high; clears the count
//   load   in   load strobe
//   value  in   WIDTH-bit load value
//   zero   out  1 when the count is zero

module pulse_timer
  import pulse_encoder_pkg::*;
#(
  parameter int WIDTH = `COUNTER_SIZE
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // Down-counter with load priority and saturation at zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= {WIDTH{1'b0}};
    end else if (load) begin
      count <= value;
    end else if (count != {WIDTH{1'b0}}) begin
      count <= count - {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

  assign zero = (count == {WIDTH{1'b0}});

endmodule

// File: rtl/pulse_encoder.sv
// pulse_encoder
//   Transmit-side optical-link encoder. An accepted packet is sent as a start
//   pulse followed by one single-cycle pulse per bit, LSB first; the number of
//   low cycles before each bit's pulse encodes the bit (INTERVAL_HIGH for 1,
//   INTERVAL_LOW for 0). After the last pulse a guard interval of low cycles
//   runs, then done strobes for one cycle.
// Optional feature: define ENCODER_BUF_EN to add a one-entry holding buffer so
//   a second packet can be queued while one is being transmitted.
// Ports:
//   clock   in   system clock, posedge
//   reset   in   synchronous, active-high
//   data    in   PACKET_SIZE-bit packet, sampled on accept
//   send    in   request; accepted when send=1 and ready=1
//   ready   out  registered; a packet can be accepted this cycle
//   signal  out  registered LED drive; 1 = pulse
//   done    out  registered; 1-cycle strobe when the guard interval completes

module pulse_encoder
  import pulse_encoder_pkg::*;
#(
  parameter int PACKET_SIZE    = `PACKET_SIZE,
  parameter int COUNTER_SIZE   = `COUNTER_SIZE,
  parameter int INTERVAL_LOW   = `INTERVAL_LOW,
  parameter int INTERVAL_HIGH  = `INTERVAL_HIGH,
  parameter int GUARD_INTERVAL = `GUARD_INTERVAL
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [PACKET_SIZE-1:0] data,
  input  logic                   send,
  output logic                   ready,
  output logic                   signal,
  output logic                   done
);

  localparam int IDX_W = $clog2(PACKET_SIZE + 1);
  localparam logic [COUNTER_SIZE-1:0] LOAD_LOW   = COUNTER_SIZE'(interval_load(INTERVAL_LOW));
  localparam logic [COUNTER_SIZE-1:0] LOAD_HIGH  = COUNTER_SIZE'(interval_load(INTERVAL_HIGH));
  localparam logic [COUNTER_SIZE-1:0] LOAD_GUARD = COUNTER_SIZE'(interval_load(GUARD_INTERVAL));

  enc_state_t              state;
  logic [PACKET_SIZE-1:0]  shift;
  // Pulses still owed after the current one; 0 while in the last pulse.
  logic [IDX_W-1:0]        bits_left;

  logic                    timer_load;
  logic [COUNTER_SIZE-1:0] timer_value;
  logic                    timer_zero;

  logic                    accept;
  logic                    guard_end;
  logic                    start;
  logic [PACKET_SIZE-1:0]  start_data;

`ifdef ENCODER_BUF_EN
  logic [PACKET_SIZE-1:0]  hold_data;
  logic                    hold_valid;
  logic                    queue;
  logic                    pop;
`endif

  pulse_timer #(
    .WIDTH (COUNTER_SIZE)
  ) u_timer (
    .clock (clock),
    .reset (reset),
    .load  (timer_load),
    .value (timer_value),
    .zero  (timer_zero)
  );

  // Every pulse cycle arms the timer: the gap for the next bit, or the guard after the last pulse.
  always_comb begin
    timer_load  = 1'b0;
    timer_value = LOAD_GUARD;
    if (state == ST_PULSE) begin
      timer_load = 1'b1;
      if (bits_left == {IDX_W{1'b0}}) begin
        timer_value = LOAD_GUARD;
      end else if (shift[0]) begin
        timer_value = LOAD_HIGH;
      end else begin
        timer_value = LOAD_LOW;
      end
    end else begin
      timer_load = 1'b0;
    end
  end

  // Decide whether a packet starts this cycle and where its data comes from.
  always_comb begin
    accept    = send & ready;
    guard_end = (state == ST_GUARD) & timer_zero;
`ifdef ENCODER_BUF_EN
    // A queued packet leaves the buffer the moment the guard ends; a fresh
    // accept starts directly when the encoder is (or is just becoming) free.
    pop        = guard_end & hold_valid;
    start      = pop | (accept & ((state == ST_IDLE) | (guard_end & ~hold_valid)));
    queue      = accept & ~start;
    start_data = pop ? hold_data : data;
`else
    start      = accept & (state == ST_IDLE);
    start_data = data;
`endif
  end

  // Encoder state machine with registered LED drive, ready and done.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      shift     <= {PACKET_SIZE{1'b0}};
      bits_left <= {IDX_W{1'b0}};
      signal    <= 1'b0;
      ready     <= 1'b1;
      done      <= 1'b0;
    end else begin
      signal <= start | ((state == ST_GAP) & timer_zero);
      done   <= guard_end;

      case (state)
        ST_IDLE: begin
          state <= ST_IDLE;
        end
        ST_PULSE: begin
          if (bits_left == {IDX_W{1'b0}}) begin
            state <= ST_GUARD;
          end else begin
            state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (timer_zero) begin
            shift     <= shift >> 1'b1;
            bits_left <= bits_left - IDX_W'(1);
            state     <= ST_PULSE;
          end else begin
            state <= ST_GAP;
          end
        end
        ST_GUARD: begin
          if (timer_zero) begin
            state <= ST_IDLE;
          end else begin
            state <= ST_GUARD;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase

      // A new packet overrides the IDLE/GUARD exit decided above.
      if (start) begin
        shift     <= start_data;
        bits_left <= IDX_W'(PACKET_SIZE);
        state     <= ST_PULSE;
      end

`ifdef ENCODER_BUF_EN
      ready <= ~((hold_valid & ~pop) | queue);
`else
      if (start) begin
        ready <= 1'b0;
      end else if (guard_end) begin
        ready <= 1'b1;
      end else begin
        ready <= ready;
      end
`endif
    end
  end

`ifdef ENCODER_BUF_EN
  // One-entry holding buffer for a packet accepted while busy.
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_valid <= 1'b0;
      hold_data  <= {PACKET_SIZE{1'b0}};
    end else if (pop) begin
      hold_valid <= 1'b0;
    end else if (queue) begin
      hold_valid <= 1'b1;
      hold_data  <= data;
    end else begin
      hold_valid <= hold_valid;
    end
  end
`endif

endmodule
